// File: rtl/snake_pkg.sv
// Shared types and constants for the snake heading controller.
// Directions follow the compass order N, E, S, W so a turn is just +/-1 modulo 4.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_N = 2'd0;
  localparam dir_t DIR_E = 2'd1;
  localparam dir_t DIR_S = 2'd2;
  localparam dir_t DIR_W = 2'd3;

  typedef enum logic {
    TURN_L = 1'b0,
    TURN_R = 1'b1
  } turn_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Wrap-around in the 2-bit heading gives the modulo-4 turn for free.
  function automatic dir_t apply_turn(input dir_t d, input turn_t t);
    return (t == TURN_R) ? dir_t'(d + 2'd1) : dir_t'(d - 2'd1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for one debounced button level.
// The previous-level register resets to 1 so a button held through reset yields no edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: queues button turns and applies one per game tick.
// Handshake: there is no back-pressure; step and turn_drop are single-cycle registered pulses.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter logic [1:0] INIT_DIR = 2'd1,
  parameter int         QDEPTH   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       enable,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       step,
  output logic [1:0] qcount,
  output logic       turn_drop,
  output logic       state_dbg
);

  localparam logic [1:0] QDEPTH_C = 2'(QDEPTH);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic [1:0] cnt_q, cnt_d;
  turn_t      tq_q [4];
  turn_t      tq_d [4];
  logic       step_q, step_d;
  logic       drop_q, drop_d;

  logic       edge_l, edge_r;
  logic       run_active, flush;
  logic       single, q_full, deq, enq;
  logic [1:0] wr_idx;
  turn_t      turn_in;

  rise_detect u_rise_left (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_left),
    .rise_o (edge_l)
  );

  rise_detect u_rise_right (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_right),
    .rise_o (edge_r)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: a RUN cycle with enable low is the leaving cycle and flushes the queue.
  always_comb begin
    run_active = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (enable) run_active = 1'b1;
        else        flush      = 1'b1;
      end
      default: ;
    endcase
  end

  // Simultaneous opposite edges cancel; a full queue still accepts when a dequeue frees a slot.
  always_comb begin
    single  = edge_l ^ edge_r;
    turn_in = edge_r ? TURN_R : TURN_L;
    q_full  = (cnt_q == QDEPTH_C);
    deq     = run_active & tick & (cnt_q != 2'd0);
    enq     = run_active & single & (~q_full | deq);
    drop_d  = run_active & single & q_full & ~deq;
    step_d  = run_active & tick;
    wr_idx  = cnt_q - 2'(deq);
  end

  // Queue and heading update; the new turn lands behind any entries that remain after the pop.
  always_comb begin
    tq_d  = tq_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (deq) begin
      tq_d[0] = tq_q[1];
      tq_d[1] = tq_q[2];
      tq_d[2] = tq_q[3];
      dir_d   = apply_turn(dir_q, tq_q[0]);
    end
    if (enq) tq_d[wr_idx] = turn_in;
    if (flush) cnt_d = 2'd0;
    else       cnt_d = cnt_q + 2'(enq) - 2'(deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q  <= INIT_DIR;
      cnt_q  <= 2'd0;
      step_q <= 1'b0;
      drop_q <= 1'b0;
      for (int i = 0; i < 4; i++) tq_q[i] <= TURN_L;
    end else begin
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      drop_q <= drop_d;
      tq_q   <= tq_d;
    end
  end

  assign dir       = dir_q;
  assign step      = step_q;
  assign qcount    = cnt_q;
  assign turn_drop = drop_q;
  assign state_dbg = (state_q == ST_RUN);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random play, checked against a queue-based model.
module tb_snake_dir_ctrl;

  localparam int INIT_DIR = 1;
  localparam int QDEPTH   = 2;
  localparam int W        = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic       step;
  logic [1:0] qcount;
  logic       turn_drop;
  logic       state_dbg;

  int checks = 0;
  int errors = 0;

  // expected word: {run, dir[1:0], step, qcount[1:0], drop}
  logic [W-1:0] exp_q[$];

  // reference model state
  int m_dir = INIT_DIR;
  bit m_run = 1'b0;
  bit m_pl  = 1'b1;
  bit m_pr  = 1'b1;
  bit turnq[$];

  snake_dir_ctrl #(.INIT_DIR(2'(INIT_DIR)), .QDEPTH(QDEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .enable    (enable),
    .tick      (tick),
    .dir       (dir),
    .step      (step),
    .qcount    (qcount),
    .turn_drop (turn_drop),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: one clock of the game rules, returns the expected registered outputs
  task automatic model_cycle(input bit rs, input bit bl, input bit br, input bit en, input bit tk);
    bit el, er, exp_step, exp_drop, t;
    int n;
    exp_step = 1'b0;
    exp_drop = 1'b0;
    if (rs) begin
      m_dir = INIT_DIR;
      turnq.delete();
      m_run = 1'b0;
      m_pl  = 1'b1;
      m_pr  = 1'b1;
    end else begin
      el = bl && !m_pl;
      er = br && !m_pr;
      m_pl = bl;
      m_pr = br;
      if (m_run && !en) begin
        turnq.delete();
        m_run = 1'b0;
      end else if (m_run) begin
        n = turnq.size();
        if (tk) begin
          exp_step = 1'b1;
          if (n > 0) begin
            t = turnq.pop_front();
            m_dir = (m_dir + (t ? 1 : 3)) % 4;
          end
        end
        if (el != er) begin
          if (n < QDEPTH || (tk && n > 0)) turnq.push_back(er);
          else exp_drop = 1'b1;
        end
      end else if (en) begin
        m_run = 1'b1;
      end
    end
    exp_q.push_back({m_run, 2'(m_dir), exp_step, 2'(turnq.size()), exp_drop});
  endtask

  // driver: inputs change on the falling edge, expectation queued for the next rising edge
  task automatic cyc(input bit rs, input bit bl, input bit br, input bit en, input bit tk);
    @(negedge clk);
    rst       = rs;
    btn_left  = bl;
    btn_right = br;
    enable    = en;
    tick      = tk;
    model_cycle(rs, bl, br, en, tk);
  endtask

  task automatic press(input bit bl, input bit br, input bit tk);
    cyc(1'b0, bl, br, 1'b1, tk);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, en, 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state_run", int'(state_dbg), int'(e[6]));
        chk("dir",       int'(dir),       int'(e[5:4]));
        chk("step",      int'(step),      int'(e[3]));
        chk("qcount",    int'(qcount),    int'(e[2:1]));
        chk("turn_drop", int'(turn_drop), int'(e[0]));
      end
    end
  end

  initial begin
    bit bl, br, en, tk, rs;

    // reset with left held, release, then let go: no enqueue expected
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // plain tick
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // left then right, two ticks
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // three rights with depth 2: one drop, then drain
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // both buttons in the same cycle
    press(1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // full queue, edge plus tick together
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // edge plus tick on empty queue: applied on the next tick
    press(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);

    // one queued turn then pause: flush, heading held, ticks/edges ignored
    press(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // reset mid-game with tick, enable and edge present
    press(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // random play
    bl = 1'b0;
    br = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) bl = ~bl;
      if ($urandom_range(0, 2) == 0) br = ~br;
      en = ($urandom_range(0, 15) != 0);
      tk = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cyc(rs, bl, br, en, tk);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
